expr_eval_ctrl: RTL and testbench
=================================

EXPR_EVAL_CTRL -- requirements
Module: expr_eval_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, bit width of the result accumulator and out_value.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  in_data holds one ASCII character.
REQ-005 in_ready  output  1  block accepts a character this cycle.
REQ-006 in_data  input  8  ASCII character.
REQ-007 in_last  input  1  current character is the final character of the expression.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_value  output  WIDTH  evaluated expression value; 0 when illegal.
REQ-011 out_legal  output  1  expression matched the grammar.

Function
REQ-012 A character is accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-013 Grammar: single-digit operand ('0'-'9'), then zero or more pairs of (operator, single-digit operand); operators are '+' and '*' ('-' per REQ-027).
REQ-014 States: EXP_DIG (reset state), EXP_OP, ERR, DONE.
REQ-015 EXP_DIG: on digit, go to EXP_OP; on any other character, go to ERR.
REQ-016 EXP_OP: on operator, go to EXP_DIG; on any other character, including a digit, go to ERR.
REQ-017 If an accepted character has in_last=1, go to DONE regardless of the above. out_legal=1 only if that character is a digit accepted in EXP_DIG and ERR was never entered.
REQ-018 ERR: consume characters without evaluating until in_last; then go to DONE with out_legal=0 and out_value=0.
REQ-019 Evaluation uses standard precedence ('*' before '+') in one pass:
- sum register, initialised to 0.
- prod register.
- pend_mul flag.
- On digit d: prod <= pend_mul ? prod*d : d.
- On '+': sum <= sum+prod, pend_mul <= 0.
- On '*': pend_mul <= 1.
REQ-020 Final value is sum+prod, including the digit accepted with in_last. All arithmetic is modulo 2^WIDTH with no overflow flag.
REQ-021 out_valid rises on the first edge after the in_last character is accepted (latency 1). out_value and out_legal stay stable while out_valid=1.
REQ-022 in_ready = 1 in every state except DONE; in_ready = 0 while out_valid = 1.
REQ-023 DONE: when out_valid and out_ready are both 1, on the next edge:
- clear out_valid;
- clear sum, prod and pend_mul;
- return to EXP_DIG.
A new character is accepted one cycle later at the earliest.
REQ-024 in_data is ignored when in_valid=0. The FSM holds its state indefinitely under in_valid=0 or out_ready=0.

Reset
REQ-025 clr=1 forces the following immediately, without waiting for clk, including mid-expression and while out_valid=1; the partial expression is discarded:
- state = EXP_DIG;
- sum = 0, prod = 0, pend_mul = 0, sign = 0;
- out_valid = 0, out_value = 0, out_legal = 0.
REQ-026 in_ready is 1 in the first cycle after clr deasserts.

Configuration
REQ-027 Macro EXPR_SUB_OP_EN: when defined, '-' (0x2D) is a legal operator, tracked by a sign register.
- On '+' or '-': sum <= sum ± prod, using the sign of the preceding term.
- Then set sign to match the operator.
- Final value is sum ± prod.
- When the macro is undefined, '-' is an illegal character (REQ-016), and no sign register exists.

Structure
REQ-028 Shared package expr_pkg holds:
- state enum: EXP_DIG, EXP_OP, ERR, DONE;
- ASCII constants for '0', '9', '+', '*', '-'.
REQ-029 Sub-module expr_char_class: combinational, in_data -> is_digit, is_add, is_mul, is_sub (is_sub tied 0 without EXPR_SUB_OP_EN), digit_val[3:0].

Verification
REQ-030 Stream "1+2*3" (last on '3'), out_ready=1 -> out_valid one cycle after '3', out_value=7, out_legal=1.
REQ-031 Stream "12" -> out_legal=0, out_value=0. Stream "3*" -> out_legal=0. Stream "9" -> out_value=9, out_legal=1.
REQ-032 Stream "9*9*9*9*9*9*9*9*9*9*9" with WIDTH=32 -> out_value=31381059609 mod 2^32 = 1316288537, out_legal=1.
REQ-033 out_ready=0 for 5 cycles after result -> out_value held, in_ready=0, in_valid characters not consumed; first character accepted 2 cycles after out_ready=1.
REQ-034 Assert clr after "4+" mid-stream, then send "5" with in_last -> out_value=5, out_legal=1.
REQ-035 With EXPR_SUB_OP_EN: "9-2*3" -> out_value=3, out_legal=1. Without it: same stream -> out_legal=0.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared types and character constants for the expression evaluator.
package expr_pkg;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    EXP_DIG = 2'd0,
    EXP_OP  = 2'd1,
    ERR     = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [CHAR_W-1:0] CH_0   = 8'h30;
  localparam logic [CHAR_W-1:0] CH_9   = 8'h39;
  localparam logic [CHAR_W-1:0] CH_ADD = 8'h2B;
  localparam logic [CHAR_W-1:0] CH_MUL = 8'h2A;
  localparam logic [CHAR_W-1:0] CH_SUB = 8'h2D;

endpackage

// File: rtl/expr_eval_ctrl_if.sv
// Character-in / result-out handshake bundle of the expression evaluator.
interface expr_eval_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  import expr_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_value;
  logic              out_legal;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_legal
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_value, out_legal
  );

endinterface

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier; '-' is recognised only when EXPR_SUB_OP_EN is defined.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [CHAR_W-1:0]  data_i,
  output logic               is_digit_c_o,
  output logic               is_add_c_o,
  output logic               is_mul_c_o,
  output logic               is_sub_c_o,
  output logic [DIGIT_W-1:0] digit_val_c_o
);

  assign is_digit_c_o  = (data_i >= CH_0) && (data_i <= CH_9);
  assign is_add_c_o    = (data_i == CH_ADD);
  assign is_mul_c_o    = (data_i == CH_MUL);
  assign digit_val_c_o = data_i[DIGIT_W-1:0];

`ifdef EXPR_SUB_OP_EN
  assign is_sub_c_o = (data_i == CH_SUB);
`else
  assign is_sub_c_o = 1'b0;
`endif

endmodule

// File: rtl/expr_eval_ctrl.sv
// Streaming single-digit infix evaluator with '*' over '+' precedence.
// Optional '-' operator enabled by defining EXPR_SUB_OP_EN.
module expr_eval_ctrl
  import expr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            clr,
  expr_eval_ctrl_if.slave bus
);

  logic               is_digit;
  logic               is_add;
  logic               is_mul;
  logic               is_sub;
  logic [DIGIT_W-1:0] digit_val;

  expr_char_class u_char_class (
    .data_i        (bus.in_data),
    .is_digit_c_o  (is_digit),
    .is_add_c_o    (is_add),
    .is_mul_c_o    (is_mul),
    .is_sub_c_o    (is_sub),
    .digit_val_c_o (digit_val)
  );

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic [WIDTH-1:0] prod_q,      prod_d;
  logic             pend_mul_q,  pend_mul_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic             out_legal_q, out_legal_d;
`ifdef EXPR_SUB_OP_EN
  logic             sign_q,      sign_d;
`endif

  logic             accept;
  logic             last_legal;
  logic [WIDTH-1:0] prod_dig;
  logic [WIDTH-1:0] fold_op;
  logic [WIDTH-1:0] fold_fin;

  assign accept   = bus.in_valid && in_ready_q;
  assign prod_dig = pend_mul_q ? WIDTH'(prod_q * WIDTH'(digit_val)) : WIDTH'(digit_val);

  // fold_op closes the current term on an operator; fold_fin closes it on the last digit
`ifdef EXPR_SUB_OP_EN
  assign fold_op  = sign_q ? (sum_q - prod_q)   : (sum_q + prod_q);
  assign fold_fin = sign_q ? (sum_q - prod_dig) : (sum_q + prod_dig);
`else
  assign fold_op  = sum_q + prod_q;
  assign fold_fin = sum_q + prod_dig;
`endif

  assign last_legal = (state_q == EXP_DIG) && is_digit;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    prod_d      = prod_q;
    pend_mul_d  = pend_mul_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_legal_d = out_legal_q;
`ifdef EXPR_SUB_OP_EN
    sign_d      = sign_q;
`endif

    unique case (state_q)
      EXP_DIG: begin
        if (accept) begin
          if (is_digit) begin
            prod_d  = prod_dig;
            state_d = EXP_OP;
          end else begin
            state_d = ERR;
          end
        end
      end
      EXP_OP: begin
        if (accept) begin
          if (is_add || is_sub) begin
            sum_d      = fold_op;
            pend_mul_d = 1'b0;
`ifdef EXPR_SUB_OP_EN
            sign_d     = is_sub;
`endif
            state_d    = EXP_DIG;
          end else if (is_mul) begin
            pend_mul_d = 1'b1;
            state_d    = EXP_DIG;
          end else begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          sum_d       = '0;
          prod_d      = '0;
          pend_mul_d  = 1'b0;
`ifdef EXPR_SUB_OP_EN
          sign_d      = 1'b0;
`endif
          state_d     = EXP_DIG;
        end
      end
      default: state_d = EXP_DIG;
    endcase

    // The final character overrides the grammar transition and publishes the result
    if (accept && bus.in_last) begin
      state_d     = DONE;
      out_valid_d = 1'b1;
      out_legal_d = last_legal;
      out_value_d = last_legal ? fold_fin : '0;
    end
  end

  assign in_ready_d = (state_d != DONE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= EXP_DIG;
      sum_q       <= '0;
      prod_q      <= '0;
      pend_mul_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_legal_q <= 1'b0;
`ifdef EXPR_SUB_OP_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      prod_q      <= prod_d;
      pend_mul_q  <= pend_mul_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_legal_q <= out_legal_d;
`ifdef EXPR_SUB_OP_EN
      sign_q      <= sign_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_legal = out_legal_q;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Directed self-checking bench for expr_eval_ctrl (honours EXPR_SUB_OP_EN).
module tb_expr_eval_ctrl;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_bad;

  expr_eval_ctrl_if #(.WIDTH(WIDTH)) bus ();

  expr_eval_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one character; returns 1ns after the edge that accepted it
  task automatic send_char(input logic [7:0] c, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h41;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], (i == s.len() - 1));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h35;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge: result must already be valid, then drain it
  task automatic check_result(input string tag, input logic [63:0] val, input logic legal);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_value"}, 64'(bus.out_value), val);
    check({tag, "_legal"}, 64'(bus.out_legal), 64'(legal));
    check({tag, "_rdy_lo"}, 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_expr(input string s, input logic [63:0] val, input logic legal);
    send_str(s);
    check_result(s, val, legal);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_value", 64'(bus.out_value), 64'd0);
    check("rst_legal", 64'(bus.out_legal), 64'd0);
    clr = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    run_expr("1+2*3", 64'd7, 1'b1);
    run_expr("12", 64'd0, 1'b0);
    run_expr("3*", 64'd0, 1'b0);
    run_expr("9", 64'd9, 1'b1);
    run_expr("9*9*9*9*9*9*9*9*9*9*9", 64'd1316288537, 1'b1);
`ifdef EXPR_SUB_OP_EN
    run_expr("9-2*3", 64'd3, 1'b1);
    run_expr("2-7", 64'hFFFF_FFFB, 1'b1);
`else
    run_expr("9-2*3", 64'd0, 1'b0);
`endif
    run_expr("2*3+4*5+6", 64'd32, 1'b1);
    run_expr("+1", 64'd0, 1'b0);
    run_expr("0*7+8", 64'd8, 1'b1);
    run_expr("5+5+5+5", 64'd20, 1'b1);
    run_expr("a", 64'd0, 1'b0);

    // Idle gaps with in_valid low must not disturb the expression
    send_char("1", 1'b0);
    send_char("+", 1'b0);
    idle(3);
    send_char("4", 1'b0);
    send_char("*", 1'b0);
    idle(2);
    send_char("2", 1'b1);
    check_result("gap", 64'd9, 1'b1);

    // Backpressure on the result: input blocked, value held
    send_str("6*7");
    bus.in_valid = 1'b1;
    bus.in_data  = "3";
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_value", 64'(bus.out_value), 64'd42);
      check("hold_rdy", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("rel_valid", 64'(bus.out_valid), 64'd0);
    check("rel_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_result("after_hold", 64'd3, 1'b1);

    // Asynchronous clear mid-expression
    send_char("4", 1'b0);
    send_char("+", 1'b0);
    #2;
    clr = 1'b1;
    #1;
    check("clr_mid_valid", 64'(bus.out_valid), 64'd0);
    check("clr_mid_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    clr = 1'b0;
    send_char("5", 1'b1);
    check_result("clr_mid", 64'd5, 1'b1);

    // Asynchronous clear while a result is pending, no clock edge in between
    send_char("8", 1'b1);
    check("clr_res_pre", 64'(bus.out_value), 64'd8);
    #2;
    clr = 1'b1;
    #1;
    check("clr_res_valid", 64'(bus.out_valid), 64'd0);
    check("clr_res_value", 64'(bus.out_value), 64'd0);
    check("clr_res_legal", 64'(bus.out_legal), 64'd0);
    clr = 1'b0;
    @(posedge clk);
    #1;
    run_expr("3+4", 64'd7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
